// File: rtl/instr_prefetch_pkg.sv
// Shared types and defaults for the instruction prefetch stage.
package instr_prefetch_pkg;

  localparam int          PF_ADDR_W   = 32;
  localparam int          PF_INSTR_W  = 32;
  localparam int          WORDSIZE    = 4;
  localparam logic [31:0] PF_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_prefetch_if.sv
// Memory read port, redirect input and instruction output stream of the prefetch stage.
interface instr_prefetch_if
  import instr_prefetch_pkg::*;
#(
  parameter int ADDR_W  = PF_ADDR_W,
  parameter int INSTR_W = PF_INSTR_W
);

  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_gnt;
  logic               mem_rvalid;
  logic [INSTR_W-1:0] mem_rdata;

  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;

  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;

  modport master (
    output mem_req, mem_addr, out_valid, out_instr, out_pc,
    input  mem_gnt, mem_rvalid, mem_rdata, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  mem_req, mem_addr, out_valid, out_instr, out_pc,
    output mem_gnt, mem_rvalid, mem_rdata, redirect_valid, redirect_pc, out_ready
  );

endinterface

// File: rtl/instr_prefetch_fetch_fifo.sv
// First-word-fall-through queue of {pc, instr} entries with synchronous flush.
module fetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                       c,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count,
  output logic [$clog2(DEPTH):0]     count_nxt,
  output logic                       valid,
  output logic [W-1:0]               dout
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          pop_ok, push_ok;

  assign pop_ok  = pop && (count != '0);
  assign push_ok = push && ((count != CW'(DEPTH)) || pop_ok);

  always_comb begin
    count_nxt = count + CW'(push_ok) - CW'(pop_ok);
    if (flush) count_nxt = '0;
  end

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
    end
  end

  assign valid = (count != '0);
  assign dout  = mem[rd_ptr];

endmodule

// File: rtl/instr_prefetch.sv
// Sequential (not-taken) instruction fetch with one outstanding read and redirect flush.
//  state | meaning
//  IDLE  | may request; mem_req while the queue has room
//  WAIT  | one read in flight, its word will be queued
//  DROP  | one read in flight from a flushed stream, its word is discarded
module instr_prefetch
  import instr_prefetch_pkg::*;
#(
  parameter int                ADDR_W   = PF_ADDR_W,
  parameter int                INSTR_W  = PF_INSTR_W,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(PF_RESET_PC)
) (
  input  logic             c,
  input  logic             rst_n,
  instr_prefetch_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e              state;
  logic [ADDR_W-1:0]         fetch_pc, inflight_pc, redir_pc;
  logic                      mem_req_q, grant, push, pop, flush, room_nxt;
  logic                      out_valid;
  logic [CW-1:0]             count, count_nxt;
  logic [ADDR_W+INSTR_W-1:0] head;

  assign redir_pc = bus.redirect_pc & ~ADDR_W'(3);
  assign flush    = bus.redirect_valid;
  assign grant    = mem_req_q && bus.mem_gnt;
  assign push     = (state == WAIT) && bus.mem_rvalid && !flush;
  assign pop      = out_valid && bus.out_ready;
  assign room_nxt = (count_nxt < CW'(DEPTH));

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      inflight_pc <= '0;
      mem_req_q   <= 1'b0;
    end else begin
      mem_req_q <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            inflight_pc <= fetch_pc;
            fetch_pc    <= fetch_pc + ADDR_W'(WORDSIZE);
            state       <= flush ? DROP : WAIT;
          end else begin
            mem_req_q <= room_nxt;
          end
        end
        WAIT: begin
          if (bus.mem_rvalid) begin
            state     <= IDLE;
            mem_req_q <= room_nxt;
          end else if (flush) begin
            state <= DROP;
          end
        end
        DROP: begin
          if (bus.mem_rvalid) begin
            state     <= IDLE;
            mem_req_q <= room_nxt;
          end
        end
        default: state <= IDLE;
      endcase
      // a redirect always wins over the sequential increment
      if (flush) fetch_pc <= redir_pc;
    end
  end

  fetch_fifo #(
    .W     (ADDR_W + INSTR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .c         (c),
    .rst_n     (rst_n),
    .push      (push),
    .din       ({inflight_pc, bus.mem_rdata}),
    .pop       (pop),
    .flush     (flush),
    .count     (count),
    .count_nxt (count_nxt),
    .valid     (out_valid),
    .dout      (head)
  );

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = fetch_pc;
  assign bus.out_valid = out_valid;
  assign bus.out_pc    = head[ADDR_W+INSTR_W-1:INSTR_W];
  assign bus.out_instr = head[INSTR_W-1:0];

endmodule

// File: tb/tb_instr_prefetch.sv
// Randomized and directed checks of instr_prefetch against a transaction-level fetch model.
module tb_instr_prefetch;

  localparam int DEPTH = 4;

  logic c = 1'b0;
  logic rst_n;

  always #5 c = ~c;

  instr_prefetch_if #(.ADDR_W(32), .INSTR_W(32)) bus ();
  instr_prefetch_if #(.ADDR_W(32), .INSTR_W(32)) bus_hi ();

  instr_prefetch #(.DEPTH(DEPTH)) u_dut (
    .c     (c),
    .rst_n (rst_n),
    .bus   (bus)
  );

  instr_prefetch #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) u_dut_hi (
    .c     (c),
    .rst_n (rst_n),
    .bus   (bus_hi)
  );

  int n_chk = 0;
  int n_err = 0;

  // model: next sequential fetch address, in-flight request, delivered-word queue
  logic [31:0] m_pc;
  logic        m_out, m_killed;
  logic [31:0] m_pend_pc;
  logic [63:0] mq[$];

  // memory responder
  logic        r_pend;
  int          r_dly;
  logic [31:0] r_addr;
  logic        hi_pend;
  logic [31:0] hi_addrs[$];

  // stimulus knobs
  int unsigned p_gnt, p_ready, p_redir, min_dly, max_dly;
  int          redir_mode;
  logic [31:0] redir_target;
  int          n_pop, n_grant;
  logic        watch_grant, watch_pop;
  logic [31:0] cap_grant, cap_pop;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] memword(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h1234_5678;
  endfunction

  task automatic idle_inputs();
    bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;
    bus.redirect_valid = 0; bus.redirect_pc = 0; bus.out_ready = 0;
    bus_hi.mem_gnt = 0; bus_hi.mem_rvalid = 0; bus_hi.mem_rdata = 0;
    bus_hi.redirect_valid = 0; bus_hi.redirect_pc = 0; bus_hi.out_ready = 0;
  endtask

  task automatic model_clear();
    mq.delete();
    m_pc = 32'h0; m_out = 0; m_killed = 0; m_pend_pc = 0;
    r_pend = 0; r_dly = 0; r_addr = 0; hi_pend = 0;
    redir_mode = 0;
  endtask

  task automatic apply_reset();
    rst_n = 0;
    idle_inputs();
    model_clear();
    repeat (2) @(negedge c);
    rst_n = 1;
  endtask

  task automatic arm_watch();
    watch_grant = 1; watch_pop = 1;
    cap_grant = 32'hDEAD_BEEF; cap_pop = 32'hDEAD_BEEF;
  endtask

  // one clock: check outputs, drive this cycle's inputs, advance the model across the edge
  task automatic step();
    logic        gnt, rv, rdy, rdr, grant, pop, forced;
    logic [31:0] rpc;
    @(posedge c); #1;
    chk("out_valid", bus.out_valid, mq.size() != 0);
    chk("mem_req", bus.mem_req, !m_out && (mq.size() < DEPTH));

    gnt = ($urandom_range(99) < p_gnt);
    rv  = r_pend && (r_dly == 0);
    rdy = ($urandom_range(99) < p_ready);
    rdr = 0; forced = 0;
    rpc = $urandom;
    case (redir_mode)
      1: rdr = ($urandom_range(99) < p_redir);
      2: rdr = bus.mem_req && gnt;
      3: rdr = rv;
      4: rdr = r_pend && !rv;
      default: rdr = 0;
    endcase
    if (redir_mode >= 2 && rdr) begin
      rpc = redir_target; forced = 1; redir_mode = 0;
    end
    assert (!rv || m_out) else $error("protocol: rvalid with no request in flight");

    bus.mem_gnt        = gnt;
    bus.mem_rvalid     = rv;
    bus.mem_rdata      = rv ? memword(r_addr) : $urandom;
    bus.out_ready      = rdy;
    bus.redirect_valid = rdr;
    bus.redirect_pc    = rpc;

    bus_hi.mem_gnt    = 1;
    bus_hi.mem_rvalid = hi_pend;
    bus_hi.out_ready  = 1;
    if (bus_hi.mem_req && hi_addrs.size() < 3) hi_addrs.push_back(bus_hi.mem_addr);
    hi_pend = bus_hi.mem_req;

    grant = bus.mem_req && gnt;
    pop   = bus.out_valid && rdy;
    if (pop && mq.size() != 0) begin
      chk("out_pc", bus.out_pc, mq[0][63:32]);
      chk("out_instr", bus.out_instr, mq[0][31:0]);
      if (watch_pop) begin cap_pop = bus.out_pc; watch_pop = 0; end
      void'(mq.pop_front());
      n_pop++;
    end
    if (grant) begin
      chk("mem_addr", bus.mem_addr, m_pc);
      if (watch_grant) begin cap_grant = bus.mem_addr; watch_grant = 0; end
      n_grant++;
      m_pend_pc = m_pc; m_out = 1; m_killed = 0;
      m_pc = m_pc + 32'd4;
      r_pend = 1; r_addr = bus.mem_addr;
      r_dly = $urandom_range(max_dly, min_dly);
    end else if (r_pend && !rv) begin
      r_dly--;
    end
    if (rv) begin
      if (!m_killed && !rdr) mq.push_back({m_pend_pc, memword(m_pend_pc)});
      m_out = 0; r_pend = 0;
    end
    if (rdr) begin
      mq.delete();
      m_pc = rpc & ~32'd3;
      if (m_out) m_killed = 1;
    end
    if (forced) arm_watch();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    model_clear();
    watch_grant = 0; watch_pop = 0; cap_grant = 0; cap_pop = 0;
    n_pop = 0; n_grant = 0;
    p_gnt = 100; p_ready = 100; p_redir = 0; min_dly = 0; max_dly = 0;
    repeat (3) @(posedge c); #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_out_pc", bus.out_pc, 32'h0);
    chk("rst_out_instr", bus.out_instr, 32'h0);
    chk("rst_hi_mem_addr", bus_hi.mem_addr, 32'hFFFF_FFF8);
    @(negedge c); rst_n = 1;

    // sequential stream, one word every two cycles
    run(10);
    n_pop = 0;
    run(20);
    chk("t1_cadence", n_pop, 10);

    // wrap-around from a high reset PC
    chk("t5_hi_count", hi_addrs.size(), 3);
    if (hi_addrs.size() == 3) begin
      chk("t5_addr0", hi_addrs[0], 32'hFFFF_FFF8);
      chk("t5_addr1", hi_addrs[1], 32'hFFFF_FFFC);
      chk("t5_addr2", hi_addrs[2], 32'h0000_0000);
    end

    // consumer stalled: queue fills to DEPTH and fetch stops
    apply_reset();
    p_ready = 0; n_grant = 0;
    run(20);
    chk("t2_grants", n_grant, DEPTH);
    chk("t2_req_off", bus.mem_req, 0);
    chk("t2_full_valid", bus.out_valid, 1);
    p_ready = 100; watch_grant = 1; cap_grant = 32'hDEAD_BEEF;
    run(20);
    chk("t2_resume", cap_grant, 32'h10);

    // redirect while waiting on a response
    apply_reset();
    min_dly = 2; max_dly = 2;
    redir_mode = 4; redir_target = 32'h103;
    run(20);
    chk("t3_grant", cap_grant, 32'h100);
    chk("t3_pop", cap_pop, 32'h100);

    // redirect coinciding with rvalid, then with a grant
    min_dly = 0; max_dly = 0;
    redir_mode = 3; redir_target = 32'h200;
    run(15);
    chk("t4a_grant", cap_grant, 32'h200);
    chk("t4a_pop", cap_pop, 32'h200);
    redir_mode = 2; redir_target = 32'h302;
    run(15);
    chk("t4b_grant", cap_grant, 32'h300);
    chk("t4b_pop", cap_pop, 32'h300);

    // reset while a read is in flight with three words queued
    apply_reset();
    p_ready = 0; min_dly = 2; max_dly = 3;
    for (int i = 0; i < 200 && !(mq.size() == 3 && r_pend); i++) step();
    chk("t6_reached", (mq.size() == 3) && r_pend, 1);
    @(posedge c); #1;
    chk("t6_pre_valid", bus.out_valid, 1);
    rst_n = 0; #1;
    chk("t6_rst_valid", bus.out_valid, 0);
    chk("t6_rst_req", bus.mem_req, 0);
    apply_reset();
    p_ready = 100; watch_grant = 1; cap_grant = 32'hDEAD_BEEF;
    run(10);
    chk("t6_restart", cap_grant, 32'h0);

    // random traffic with occasional redirects
    apply_reset();
    p_gnt = 60; p_ready = 60; p_redir = 3; min_dly = 0; max_dly = 3;
    redir_mode = 1;
    n_pop = 0;
    run(3000);
    redir_mode = 0;
    chk("rand_progress", n_pop > 100, 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
